// File: rtl/wave_sequencer.sv
// Step sequencer that programs and runs wave_generator from an N_STEPS-entry table.
// Define WAVE_SEQUENCER_LOOP_EN to repeat the program until stop_i instead of running it once.
module wave_sequencer #(
    parameter int N_FRAC  = 7,
    parameter int N_STEPS = 4,
    parameter int CNT_W   = 8,
    localparam int ADDR_W = $clog2(N_STEPS),
    localparam int DW     = N_FRAC + 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              prog_we_i,
    input  logic [ADDR_W-1:0] prog_addr_i,
    input  logic [1:0]        prog_wave_i,
    input  logic [DW-1:0]     prog_phase_i,
    input  logic [DW-1:0]     prog_amp_i,
    input  logic [CNT_W-1:0]  prog_len_i,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              sample_valid_i,
    output logic              enable_o,
    output logic [1:0]        waveform_o,
    output logic              set_phase_strobe_o,
    output logic              set_amplitude_strobe_o,
    output logic [DW-1:0]     data_o,
    output logic              busy_o,
    output logic [ADDR_W-1:0] step_o,
    output logic              done_strobe_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_PH  = 2'd1,
        LOAD_AMP = 2'd2,
        RUN      = 2'd3
    } state_t;

    logic [1:0]        wave_mem_r  [N_STEPS];
    logic [DW-1:0]     phase_mem_r [N_STEPS];
    logic [DW-1:0]     amp_mem_r   [N_STEPS];
    logic [CNT_W-1:0]  len_mem_r   [N_STEPS];

    state_t            state_r, state_next_s;
    logic [ADDR_W-1:0] step_r, step_next_s, step_inc_s;
    logic [CNT_W-1:0]  cnt_r, cnt_next_s, len_cur_s;
    logic              enable_r, enable_next_s;
    logic [1:0]        wave_r, wave_next_s;
    logic              ph_strobe_r, ph_strobe_next_s;
    logic              amp_strobe_r, amp_strobe_next_s;
    logic [DW-1:0]     data_r, data_next_s;
    logic              busy_r, busy_next_s;
    logic              done_r, done_next_s;
    logic              step_end_s, last_step_s;

    assign len_cur_s   = len_mem_r[step_r];
    assign step_inc_s  = step_r + ADDR_W'(1);
    assign last_step_s = (step_r == ADDR_W'(N_STEPS - 1));

    // Program table: host writes land only while idle so a running program never changes under us.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < N_STEPS; i++) begin
                wave_mem_r[i]  <= 2'b00;
                phase_mem_r[i] <= {DW{1'b0}};
                amp_mem_r[i]   <= {DW{1'b0}};
                len_mem_r[i]   <= {CNT_W{1'b0}};
            end
        end else if (prog_we_i && (state_r == IDLE)) begin
            wave_mem_r[prog_addr_i]  <= prog_wave_i;
            phase_mem_r[prog_addr_i] <= prog_phase_i;
            amp_mem_r[prog_addr_i]   <= prog_amp_i;
            len_mem_r[prog_addr_i]   <= prog_len_i;
        end
    end

    // Next state plus next registered outputs; stop_i overrides everything else.
    always_comb begin
        state_next_s      = state_r;
        step_next_s       = step_r;
        cnt_next_s        = cnt_r;
        enable_next_s     = 1'b0;
        wave_next_s       = wave_r;
        ph_strobe_next_s  = 1'b0;
        amp_strobe_next_s = 1'b0;
        data_next_s       = data_r;
        busy_next_s       = 1'b1;
        done_next_s       = 1'b0;
        step_end_s        = 1'b0;

        case (state_r)
            IDLE: begin
                if (start_i) begin
                    state_next_s     = LOAD_PH;
                    step_next_s      = {ADDR_W{1'b0}};
                    cnt_next_s       = {CNT_W{1'b0}};
                    ph_strobe_next_s = 1'b1;
                    data_next_s      = phase_mem_r[0];
                    wave_next_s      = wave_mem_r[0];
                end else begin
                    busy_next_s = 1'b0;
                end
            end
            LOAD_PH: begin
                state_next_s      = LOAD_AMP;
                amp_strobe_next_s = 1'b1;
                data_next_s       = amp_mem_r[step_r];
            end
            LOAD_AMP: begin
                if (len_cur_s != {CNT_W{1'b0}}) begin
                    state_next_s  = RUN;
                    enable_next_s = 1'b1;
                end else begin
                    step_end_s = 1'b1;
                end
            end
            RUN: begin
                enable_next_s = 1'b1;
                if (sample_valid_i && (cnt_r == len_cur_s - CNT_W'(1))) begin
                    step_end_s = 1'b1;
                end else if (sample_valid_i) begin
                    cnt_next_s = cnt_r + CNT_W'(1);
                end else begin
                    cnt_next_s = cnt_r;
                end
            end
            default: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
            end
        endcase

        if (stop_i) begin
            state_next_s      = IDLE;
            step_next_s       = step_r;
            cnt_next_s        = cnt_r;
            enable_next_s     = 1'b0;
            wave_next_s       = wave_r;
            ph_strobe_next_s  = 1'b0;
            amp_strobe_next_s = 1'b0;
            data_next_s       = data_r;
            busy_next_s       = 1'b0;
            done_next_s       = 1'b0;
        end else if (step_end_s) begin
            enable_next_s = 1'b0;
            cnt_next_s    = {CNT_W{1'b0}};
            if (!last_step_s) begin
                state_next_s     = LOAD_PH;
                step_next_s      = step_inc_s;
                ph_strobe_next_s = 1'b1;
                data_next_s      = phase_mem_r[step_inc_s];
                wave_next_s      = wave_mem_r[step_inc_s];
            end else begin
                done_next_s = 1'b1;
`ifdef WAVE_SEQUENCER_LOOP_EN
                // step_inc_s wraps to entry 0 because N_STEPS is a power of two
                state_next_s     = LOAD_PH;
                step_next_s      = step_inc_s;
                ph_strobe_next_s = 1'b1;
                data_next_s      = phase_mem_r[step_inc_s];
                wave_next_s      = wave_mem_r[step_inc_s];
`else
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
`endif
            end
        end else begin
            done_next_s = 1'b0;
        end
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_r      <= IDLE;
            step_r       <= {ADDR_W{1'b0}};
            cnt_r        <= {CNT_W{1'b0}};
            enable_r     <= 1'b0;
            wave_r       <= 2'b00;
            ph_strobe_r  <= 1'b0;
            amp_strobe_r <= 1'b0;
            data_r       <= {DW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            step_r       <= step_next_s;
            cnt_r        <= cnt_next_s;
            enable_r     <= enable_next_s;
            wave_r       <= wave_next_s;
            ph_strobe_r  <= ph_strobe_next_s;
            amp_strobe_r <= amp_strobe_next_s;
            data_r       <= data_next_s;
            busy_r       <= busy_next_s;
            done_r       <= done_next_s;
        end
    end

    assign enable_o               = enable_r;
    assign waveform_o             = wave_r;
    assign set_phase_strobe_o     = ph_strobe_r;
    assign set_amplitude_strobe_o = amp_strobe_r;
    assign data_o                 = data_r;
    assign busy_o                 = busy_r;
    assign step_o                 = step_r;
    assign done_strobe_o          = done_r;

endmodule

// File: tb/tb_wave_sequencer.sv
// Scoreboard bench for wave_sequencer: expected strobe contents are queued per program pass
// and popped as the DUT strobes; sample counts and cycle gaps come from the bench's own table.
module tb_wave_sequencer;
    localparam int N_FRAC  = 7;
    localparam int N_STEPS = 4;
    localparam int CNT_W   = 8;
    localparam int ADDR_W  = 2;
    localparam int DW      = N_FRAC + 1;

    logic              clk = 1'b0;
    logic              rst_i = 1'b0;
    logic              prog_we_i = 1'b0;
    logic [ADDR_W-1:0] prog_addr_i = '0;
    logic [1:0]        prog_wave_i = '0;
    logic [DW-1:0]     prog_phase_i = '0;
    logic [DW-1:0]     prog_amp_i = '0;
    logic [CNT_W-1:0]  prog_len_i = '0;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic              sample_valid_i = 1'b0;
    logic              enable_o, set_phase_strobe_o, set_amplitude_strobe_o, busy_o, done_strobe_o;
    logic [1:0]        waveform_o;
    logic [DW-1:0]     data_o;
    logic [ADDR_W-1:0] step_o;

    always #5 clk = ~clk;

    wave_sequencer #(.N_FRAC(N_FRAC), .N_STEPS(N_STEPS), .CNT_W(CNT_W)) dut (
        .clk_i(clk), .rst_i(rst_i), .prog_we_i(prog_we_i), .prog_addr_i(prog_addr_i),
        .prog_wave_i(prog_wave_i), .prog_phase_i(prog_phase_i), .prog_amp_i(prog_amp_i),
        .prog_len_i(prog_len_i), .start_i(start_i), .stop_i(stop_i),
        .sample_valid_i(sample_valid_i), .enable_o(enable_o), .waveform_o(waveform_o),
        .set_phase_strobe_o(set_phase_strobe_o), .set_amplitude_strobe_o(set_amplitude_strobe_o),
        .data_o(data_o), .busy_o(busy_o), .step_o(step_o), .done_strobe_o(done_strobe_o)
    );

    typedef struct packed {
        logic [1:0]        wave;
        logic [DW-1:0]     data;
        logic [ADDR_W-1:0] step;
    } ph_exp_t;

    int vectors = 0;
    int miscompares = 0;

    logic [1:0]       m_wave  [N_STEPS];
    logic [DW-1:0]    m_phase [N_STEPS];
    logic [DW-1:0]    m_amp   [N_STEPS];
    logic [CNT_W-1:0] m_len   [N_STEPS];

    ph_exp_t       ph_q[$];
    logic [DW-1:0] amp_q[$];

    int ph_cyc[N_STEPS], last_cyc[N_STEPS], smp_cnt[N_STEPS], en_seen[N_STEPS];
    int first_ph, first_amp, first_en, last_any, done_cyc, done_cnt, n_smp;

`ifdef WAVE_SEQUENCER_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    task automatic prog_write(input int a, input logic [1:0] w, input logic [DW-1:0] ph,
                              input logic [DW-1:0] amp, input logic [CNT_W-1:0] len);
        @(negedge clk);
        prog_we_i = 1'b1; prog_addr_i = a[ADDR_W-1:0];
        prog_wave_i = w; prog_phase_i = ph; prog_amp_i = amp; prog_len_i = len;
        @(negedge clk);
        prog_we_i = 1'b0;
        m_wave[a] = w; m_phase[a] = ph; m_amp[a] = amp; m_len[a] = len;
    endtask

    task automatic push_pass();
        ph_exp_t e;
        int s4;
        for (int s = 0; s < N_STEPS; s++) begin
            s4 = s;
            e.wave = m_wave[s]; e.data = m_phase[s]; e.step = s4[ADDR_W-1:0];
            ph_q.push_back(e);
            amp_q.push_back(m_amp[s]);
        end
    endtask

    // Starts the program and monitors it; stop_after >= 0 aborts after that many samples.
    task automatic run_prog(input string tag, input int passes, input bit gaps,
                            input int stop_after, input bit poke);
        int cyc, total, exp_done;
        bit fin;
        ph_exp_t e;
        logic [DW-1:0] ea;
        for (int s = 0; s < N_STEPS; s++) begin
            ph_cyc[s] = -1; last_cyc[s] = -1; smp_cnt[s] = 0; en_seen[s] = 0;
        end
        first_ph = -1; first_amp = -1; first_en = -1; last_any = -1;
        done_cyc = -1; done_cnt = 0; n_smp = 0; total = 0;
        for (int s = 0; s < N_STEPS; s++) total += int'(m_len[s]);
        for (int p = 0; p < passes + (LOOP ? 1 : 0); p++) push_pass();
        @(negedge clk);
        start_i = 1'b1;
        cyc = 0; fin = 1'b0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            start_i = 1'b0; stop_i = 1'b0; sample_valid_i = 1'b0; prog_we_i = 1'b0;
            if (set_phase_strobe_o) begin
                vectors++;
                if (ph_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s phase_strobe: unexpected strobe at cycle %0d, none required", tag, cyc);
                end else begin
                    e = ph_q.pop_front();
                    if (data_o !== e.data || waveform_o !== e.wave || step_o !== e.step || enable_o !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s phase_strobe: got data=%h wave=%0d step=%0d en=%b, required data=%h wave=%0d step=%0d en=0",
                                 tag, data_o, waveform_o, step_o, enable_o, e.data, e.wave, e.step);
                    end
                end
                if (first_ph < 0) first_ph = cyc;
                ph_cyc[step_o] = cyc;
            end
            if (set_amplitude_strobe_o) begin
                vectors++;
                if (amp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL %s amp_strobe: unexpected strobe at cycle %0d, none required", tag, cyc);
                end else begin
                    ea = amp_q.pop_front();
                    if (data_o !== ea || enable_o !== 1'b0) begin
                        miscompares++;
                        $display("FAIL %s amp_strobe: got data=%h en=%b, required data=%h en=0", tag, data_o, enable_o, ea);
                    end
                end
                if (first_amp < 0) first_amp = cyc;
            end
            if (done_strobe_o) begin
                done_cnt++; done_cyc = cyc;
                vectors++;
                if (busy_o !== LOOP) begin
                    miscompares++;
                    $display("FAIL %s done_busy: got busy=%b, required %b", tag, busy_o, LOOP);
                end
                if (done_cnt == passes) begin
                    fin = 1'b1;
                    stop_i = LOOP;
                end
            end
            if (enable_o && !fin) begin
                en_seen[step_o] = 1;
                if (first_en < 0) first_en = cyc;
                if (stop_after >= 0 && n_smp == stop_after) begin
                    stop_i = 1'b1; fin = 1'b1;
                end else if (!gaps || (cyc % 3) != 0) begin
                    sample_valid_i = 1'b1; n_smp++;
                    smp_cnt[step_o]++; last_cyc[step_o] = cyc; last_any = cyc;
                end
            end
            if (poke && cyc == 2) begin
                prog_we_i = 1'b1; prog_addr_i = '0;
                prog_wave_i = ~m_wave[0]; prog_phase_i = ~m_phase[0];
                prog_amp_i = ~m_amp[0]; prog_len_i = m_len[0] + 8'd5;
                start_i = 1'b1;
            end
        end
        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL %s timeout: got no completion within %0d cycles, required completion", tag, cyc);
        end
        if (stop_after < 0) begin
            vectors++;
            if (n_smp != total * passes) begin
                miscompares++;
                $display("FAIL %s sample_total: got %0d, required %0d", tag, n_smp, total * passes);
            end
            for (int s = 0; s < N_STEPS; s++) begin
                vectors++;
                if (smp_cnt[s] != int'(m_len[s]) * passes) begin
                    miscompares++;
                    $display("FAIL %s step%0d_samples: got %0d, required %0d", tag, s, smp_cnt[s], int'(m_len[s]) * passes);
                end
            end
            exp_done = (total == 0) ? 2 * N_STEPS * passes + 1 : last_any + 1;
            vectors++;
            if (done_cyc != exp_done || done_cnt != passes) begin
                miscompares++;
                $display("FAIL %s done_timing: got cycle %0d count %0d, required cycle %0d count %0d",
                         tag, done_cyc, done_cnt, exp_done, passes);
            end
            vectors++;
            if (first_ph != 1 || first_amp != 2 || (m_len[0] != 0 && first_en != 3)) begin
                miscompares++;
                $display("FAIL %s start_latency: got ph=%0d amp=%0d en=%0d, required 1 2 3", tag, first_ph, first_amp, first_en);
            end
            if (!LOOP) begin
                vectors++;
                if (ph_q.size() != 0 || amp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL %s leftover_strobes: got %0d/%0d unconsumed, required 0/0", tag, ph_q.size(), amp_q.size());
                end
            end
        end
        @(negedge clk);
        stop_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || enable_o !== 1'b0 || done_strobe_o !== 1'b0 ||
            set_phase_strobe_o !== 1'b0 || set_amplitude_strobe_o !== 1'b0) begin
            miscompares++;
            $display("FAIL %s after_end: got busy=%b en=%b done=%b ph=%b amp=%b, required all 0",
                     tag, busy_o, enable_o, done_strobe_o, set_phase_strobe_o, set_amplitude_strobe_o);
        end
        ph_q.delete();
        amp_q.delete();
    endtask

    task automatic test_reset();
        #12;
        vectors++;
        if ({enable_o, waveform_o, set_phase_strobe_o, set_amplitude_strobe_o, data_o, busy_o, step_o, done_strobe_o} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got en=%b wave=%0d ph=%b amp=%b data=%h busy=%b step=%0d done=%b, required all 0",
                     enable_o, waveform_o, set_phase_strobe_o, set_amplitude_strobe_o, data_o, busy_o, step_o, done_strobe_o);
        end
        @(negedge clk);
        rst_i = 1'b1;
        for (int s = 0; s < N_STEPS; s++) begin
            m_wave[s] = '0; m_phase[s] = '0; m_amp[s] = '0; m_len[s] = '0;
        end
    endtask

    task automatic load_basic();
        prog_write(0, 2'd0, 8'h10, 8'h7F, 8'd3);
        prog_write(1, 2'd1, 8'h20, 8'h40, 8'd2);
        prog_write(2, 2'd2, 8'h00, 8'h60, 8'd1);
        prog_write(3, 2'd3, 8'h08, 8'h30, 8'd2);
    endtask

    task automatic test_single_pass();
        load_basic();
        run_prog("single", 1, 1'b0, -1, 1'b0);
        run_prog("single_gaps", 1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_skip();
        prog_write(1, 2'd1, 8'h20, 8'h40, 8'd0);
        run_prog("skip", 1, 1'b0, -1, 1'b0);
        vectors++;
        if (ph_cyc[1] != last_cyc[0] + 1 || ph_cyc[2] != last_cyc[0] + 3 || en_seen[1] != 0) begin
            miscompares++;
            $display("FAIL skip_gap: got ph1=%0d ph2=%0d en1=%0d after last0=%0d, required ph1=last0+1 ph2=last0+3 en1=0",
                     ph_cyc[1], ph_cyc[2], en_seen[1], last_cyc[0]);
        end
        prog_write(1, 2'd1, 8'h20, 8'h40, 8'd2);
    endtask

    task automatic test_stop();
        run_prog("stop", 1, 1'b0, 1, 1'b0);
        run_prog("restart", 1, 1'b1, -1, 1'b0);
    endtask

    task automatic test_ignored();
        run_prog("busy_poke", 1, 1'b0, -1, 1'b1);
        run_prog("after_poke", 1, 1'b0, -1, 1'b0);
        @(negedge clk);
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        vectors++;
        if (busy_o !== 1'b0 || set_phase_strobe_o !== 1'b0 || enable_o !== 1'b0) begin
            miscompares++;
            $display("FAIL start_stop_idle: got busy=%b ph=%b en=%b, required 0 0 0", busy_o, set_phase_strobe_o, enable_o);
        end
    endtask

    task automatic test_loop();
        run_prog("loop", 2, 1'b0, -1, 1'b0);
    endtask

    task automatic test_async_reset();
        int waited;
        prog_write(0, 2'd2, 8'h55, 8'h66, 8'd50);
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        waited = 0;
        while (!enable_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (enable_o !== 1'b1) begin
            miscompares++;
            $display("FAIL async_run: got enable=%b, required 1 before reset", enable_o);
        end
        #2 rst_i = 1'b0;
        #1;
        vectors++;
        if ({enable_o, waveform_o, set_phase_strobe_o, set_amplitude_strobe_o, data_o, busy_o, step_o, done_strobe_o} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got en=%b wave=%0d data=%h busy=%b step=%0d, required all 0",
                     enable_o, waveform_o, data_o, busy_o, step_o);
        end
        @(negedge clk);
        rst_i = 1'b1;
        for (int s = 0; s < N_STEPS; s++) begin
            m_wave[s] = '0; m_phase[s] = '0; m_amp[s] = '0; m_len[s] = '0;
        end
        run_prog("zero_prog", 1, 1'b0, -1, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_skip();
        test_stop();
        test_ignored();
        if (LOOP) test_loop();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
